// File: rtl/cordic_vectoring_atan2.sv
// Iterative CORDIC vectoring engine: returns atan2(y, x) in 4096-code angle units
// and the uncompensated magnitude (gain ~1.6468), one micro-rotation per clock.
module cordic_vectoring_atan2 (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] x_in,
  input  logic [11:0] y_in,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [12:0] angle_out,
  output logic [12:0] mag_out,
  output logic        out_valid,
  input  logic        out_ready
);

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

  state_t             state_q, state_d;
  logic signed [13:0] x_q, x_d, y_q, y_d, z_q, z_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               zero_q, zero_d;
  logic [12:0]        angle_q, angle_d, mag_q, mag_d;

  logic signed [13:0] x_ext, y_ext, x_sh, y_sh, atan_i;
  logic signed [13:0] x_it, y_it, z_it, z_wrap;

  assign x_ext = {{2{x_in[11]}}, x_in};
  assign y_ext = {{2{y_in[11]}}, y_in};
  assign x_sh  = x_q >>> cnt_q;
  assign y_sh  = y_q >>> cnt_q;

  always_comb begin
    case (cnt_q)
      4'd0:    atan_i = 14'sd512;
      4'd1:    atan_i = 14'sd302;
      4'd2:    atan_i = 14'sd160;
      4'd3:    atan_i = 14'sd81;
      4'd4:    atan_i = 14'sd41;
      4'd5:    atan_i = 14'sd20;
      4'd6:    atan_i = 14'sd10;
      4'd7:    atan_i = 14'sd5;
      4'd8:    atan_i = 14'sd3;
      default: atan_i = '0;
    endcase
  end

  // Drive y toward zero; the rotation direction follows the sign of the old y.
  assign x_it = y_q[13] ? x_q - y_sh : x_q + y_sh;
  assign y_it = y_q[13] ? y_q + x_sh : y_q - x_sh;
  assign z_it = y_q[13] ? z_q - atan_i : z_q + atan_i;

  always_comb begin
    if (z_it < 14'sd0)          z_wrap = z_it + 14'sd4096;
    else if (z_it >= 14'sd4096) z_wrap = z_it - 14'sd4096;
    else                        z_wrap = z_it;
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    cnt_d   = cnt_q;
    zero_d  = zero_q;
    angle_d = angle_q;
    mag_d   = mag_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          // Fold the left half-plane onto the right so the iterations converge.
          x_d     = x_ext[13] ? -x_ext : x_ext;
          y_d     = x_ext[13] ? -y_ext : y_ext;
          z_d     = x_ext[13] ? 14'sd2048 : 14'sd0;
          zero_d  = (x_in == '0) && (y_in == '0);
          cnt_d   = '0;
          state_d = ITER;
        end
      end
      ITER: begin
        x_d   = x_it;
        y_d   = y_it;
        z_d   = z_it;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd8) begin
          state_d = DONE;
          angle_d = zero_q ? '0 : z_wrap[12:0];
          mag_d   = zero_q ? '0 : x_it[12:0];
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      cnt_q   <= '0;
      zero_q  <= 1'b0;
      angle_q <= '0;
      mag_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      cnt_q   <= cnt_d;
      zero_q  <= zero_d;
      angle_q <= angle_d;
      mag_q   <= mag_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign angle_out = angle_q;
  assign mag_out   = mag_q;

endmodule

// File: tb/tb_cordic_vectoring_atan2.sv
// Scoreboard bench for cordic_vectoring_atan2: stimulus pushes expected results,
// a negedge monitor pops and checks them on each output handshake.
module tb_cordic_vectoring_atan2;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] x_in, y_in;
  logic        in_valid, in_ready;
  logic [12:0] angle_out, mag_out;
  logic        out_valid, out_ready;

  cordic_vectoring_atan2 dut (
    .clk       (clk),
    .rst       (rst),
    .x_in      (x_in),
    .y_in      (y_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .angle_out (angle_out),
    .mag_out   (mag_out),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    string nm;
    int    ea;
    int    at;
    int    em;
    int    mt;
    int    acc;
  } exp_t;

  exp_t sb[$];
  exp_t e_m;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  bit   prev_v = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int angdist(input int a, input int b);
    int d;
    d = (((a - b) % 4096) + 4096) % 4096;
    if (d > 2048) d = 4096 - d;
    return d;
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Monitor: latency on each rising out_valid, values on each handshake.
  always @(negedge clk) begin
    if (rst) begin
      prev_v = 1'b0;
    end else begin
      if (out_valid && !prev_v) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_out_valid: got out_valid=1 expected no pending result");
        end else if (cyc - sb[0].acc != 9) begin
          n_bad++;
          $display("FAIL %s latency: got %0d expected 9", sb[0].nm, cyc - sb[0].acc);
        end
      end
      if (out_valid && out_ready && sb.size() != 0) begin
        e_m = sb.pop_front();
        n_cmp++;
        if (angle_out > 13'd4095 || angdist(int'(angle_out), e_m.ea) > e_m.at) begin
          n_bad++;
          $display("FAIL %s angle: got %0d expected %0d +/-%0d", e_m.nm, angle_out, e_m.ea, e_m.at);
        end
        n_cmp++;
        if (iabs(int'(mag_out) - e_m.em) > e_m.mt) begin
          n_bad++;
          $display("FAIL %s mag: got %0d expected %0d +/-%0d", e_m.nm, mag_out, e_m.em, e_m.mt);
        end
      end
      prev_v = out_valid;
    end
  end

  // Called and returns at posedge+1; acc is the cycle count after the acceptance edge.
  task automatic send(input string nm, input int x, input int y, input int ea, input int at,
                      input int em, input int mt, input bit push, input bit keep,
                      output int acc);
    int   guard;
    exp_t e;
    guard    = 0;
    x_in     = 12'(x);
    y_in     = 12'(y);
    in_valid = 1'b1;
    while (!in_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 100) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s in_ready_timeout: got in_ready=0 expected 1 within 100 cycles", nm);
    end
    @(posedge clk); #1;
    acc = cyc;
    if (push) begin
      e.nm = nm; e.ea = ea; e.at = at; e.em = em; e.mt = mt; e.acc = acc;
      sb.push_back(e);
    end
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (sb.size() != 0 && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic ref_model(input int x, input int y, output int ea, output int em);
    real a, m;
    a = $atan2(real'(y), real'(x)) * 2048.0 / 3.14159265358979;
    if (a < 0.0) a = a + 4096.0;
    ea = int'(a);
    if (ea >= 4096) ea = ea - 4096;
    m  = 1.64676 * $sqrt(real'(x * x + y * y));
    em = int'(m);
  endtask

  typedef struct {
    string nm;
    int    x;
    int    y;
    int    ea;
    int    at;
    int    em;
    int    mt;
  } vec_t;

  vec_t dir_v[$];
  int   sx[8] = '{1000, -700, -1500, 400, 1200, -300, 50, -2048};
  int   sy[8] = '{300, 900, -200, -1800, -50, -1100, 1900, 700};

  initial begin
    int acc, prev_acc, a0, m0, viol, ea, em;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; x_in = '0; y_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_in_ready", int'(in_ready), 1);
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_angle", int'(angle_out), 0);
    chk("reset_mag", int'(mag_out), 0);
    rst = 1'b0;

    send("pos_y_axis_pre", 0, 512, 1024, 3, 843, 4, 1'b1, 1'b0, acc);
    drain();

    // Reset mid-ITER: outputs must clear asynchronously, without a clock edge.
    send("dropped", 512, 0, 0, 0, 0, 0, 1'b0, 1'b0, acc);
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midreset_out_valid", int'(out_valid), 0);
    chk("midreset_angle", int'(angle_out), 0);
    chk("midreset_mag", int'(mag_out), 0);
    chk("midreset_in_ready", int'(in_ready), 1);
    @(posedge clk); #1;
    rst = 1'b0;

    dir_v = '{
      '{"pos_x_axis",   512,    0,    0, 3,  843, 4},
      '{"pos_y_axis",     0,  512, 1024, 3,  843, 4},
      '{"neg_x_axis",  -512,    0, 2048, 3,  843, 4},
      '{"neg_y_axis",     0, -512, 3072, 3,  843, 4},
      '{"diag_q1",      362,  362,  512, 3,  843, 4},
      '{"diag_q3",     -362, -362, 2560, 3,  843, 4},
      '{"diag_q4",      362, -362, 3584, 3,  843, 4},
      '{"extreme_q3", -2048, -2048, 2560, 3, 4770, 8},
      '{"zero_vec",       0,    0,    0, 0,    0, 0}
    };
    foreach (dir_v[i]) begin
      send(dir_v[i].nm, dir_v[i].x, dir_v[i].y, dir_v[i].ea, dir_v[i].at,
           dir_v[i].em, dir_v[i].mt, 1'b1, 1'b0, acc);
      drain();
    end

    // Backpressure: result must hold for 20 cycles with out_ready low.
    out_ready = 1'b0;
    send("backpressure", 300, 400, 605, 3, 823, 4, 1'b1, 1'b0, acc);
    viol = 0;
    while (!out_valid && viol < 50) begin
      @(negedge clk);
      viol++;
    end
    chk("bp_valid_seen", int'(out_valid), 1);
    a0 = int'(angle_out);
    m0 = int'(mag_out);
    viol = 0;
    repeat (20) begin
      @(negedge clk);
      if (!out_valid || in_ready || int'(angle_out) != a0 || int'(mag_out) != m0) viol++;
    end
    chk("bp_hold_violations", viol, 0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_out_valid", int'(out_valid), 0);
    chk("bp_release_in_ready", int'(in_ready), 1);
    drain();

    // Streaming: in_valid held high, one result every 11 cycles.
    prev_acc = 0;
    for (int k = 0; k < 8; k++) begin
      ref_model(sx[k], sy[k], ea, em);
      send($sformatf("stream%0d", k), sx[k], sy[k], ea, 3, em, em / 100 + 1, 1'b1, 1'b1, acc);
      if (k > 0) chk($sformatf("stream%0d_interval", k), acc - prev_acc, 11);
      prev_acc = acc;
    end
    in_valid = 1'b0;
    drain();

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
